// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg: capture FSM state encoding and default frame geometry
package cmos_capture_pkg;
    typedef enum logic [1:0] {WAIT_CFG, SKIP, WAIT_VS, ACTIVE} capState_e;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int SKIP_FRAMES_DEF = 10;
endpackage

// File: rtl/cmos_capture_sync_edge.sv
// cmos_sync_edge: first-stage register of sensor inputs and VSYNC/HREF edge pulses
module cmos_sync_edge (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iVSYNC,
    input  logic       iHREF,
    input  logic [7:0] iDATA,
    output logic       s1Href,
    output logic [7:0] s1Data,
    output logic       vsRise,
    output logic       vsFall,
    output logic       hrefRise,
    output logic       hrefFall
);
    logic s1Vsync, vsD, hrefD;
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) {s1Vsync, s1Href, s1Data, vsD, hrefD} <= '0;
        else begin
            s1Vsync <= iVSYNC;
            s1Href  <= iHREF;
            s1Data  <= iDATA;
            vsD     <= s1Vsync;
            hrefD   <= s1Href;
        end
    assign vsRise   = s1Vsync & ~vsD;
    assign vsFall   = ~s1Vsync & vsD;
    assign hrefRise = s1Href & ~hrefD;
    assign hrefFall = ~s1Href & hrefD;
endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: CMOS sensor byte stream to RGB565 pixels with frame skipping.
// Define CMOS_CAPTURE_STATS_EN to add frame counter and size-error outputs.
module cmos_capture
    import cmos_capture_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iCONFIG_DONE,
    input  logic        iVSYNC,
    input  logic        iHREF,
    input  logic [7:0]  iDATA,
    output logic [15:0] oPIX_DATA,
    output logic        oPIX_VALID,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic        oFRAME_START,
    output logic        oFRAME_DONE,
    output logic        oCAPTURING
`ifdef CMOS_CAPTURE_STATS_EN
   ,output logic [15:0] oFRAME_CNT,
    output logic        oSIZE_ERR
`endif
);
    localparam logic [9:0]  HMAX  = 10'(H_ACTIVE);
    localparam logic [8:0]  VMAX  = 9'(V_ACTIVE);
    localparam logic [15:0] SKIPN = 16'(SKIP_FRAMES);

    capState_e   state, nextState;
    logic        s1Href, vsRise, vsFall, hrefRise, hrefFall;
    logic [7:0]  s1Data, hiByte;
    logic [15:0] skipCnt, pendData;
    logic [9:0]  x, pendX;
    logic [8:0]  y, pendY;
    logic        phase, pendValid, frameStart, frameDone, inActive, pixStrobe;

    cmos_sync_edge uSync (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVSYNC(iVSYNC), .iHREF(iHREF), .iDATA(iDATA),
        .s1Href(s1Href), .s1Data(s1Data), .vsRise(vsRise), .vsFall(vsFall),
        .hrefRise(hrefRise), .hrefFall(hrefFall)
    );

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) state <= WAIT_CFG;
        else state <= nextState;

    always_comb begin
        nextState  = state;
        frameStart = 1'b0;
        frameDone  = 1'b0;
        if (!iCONFIG_DONE) nextState = WAIT_CFG;
        else if (state == WAIT_CFG) nextState = SKIP;
        else if (state == SKIP && (SKIPN == 16'd0 || (vsFall && skipCnt == SKIPN - 16'd1))) nextState = WAIT_VS;
        else if (state == WAIT_VS && vsFall) begin
            nextState  = ACTIVE;
            frameStart = 1'b1;
        end
        else if (state == ACTIVE && vsRise) begin
            nextState = WAIT_VS;
            frameDone = 1'b1;
        end
    end

    assign inActive   = state == ACTIVE && nextState == ACTIVE;
    assign pixStrobe  = inActive && s1Href && phase && !hrefRise;
    assign oCAPTURING = state == WAIT_VS || state == ACTIVE;

    // S1 -> pairing/pending stage -> output registers: two cycles after the second byte is sampled
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            {skipCnt, x, y, phase, hiByte, pendValid, pendData, pendX, pendY} <= '0;
            {oPIX_DATA, oPIX_VALID, oX, oY, oFRAME_START, oFRAME_DONE} <= '0;
        end else begin
            skipCnt      <= (state == SKIP && nextState == SKIP) ? skipCnt + 16'(vsFall) : '0;
            oFRAME_START <= frameStart;
            oFRAME_DONE  <= frameDone;
            pendValid    <= pixStrobe && x < HMAX && y < VMAX;
            oPIX_VALID   <= pendValid;
            if (pendValid) {oPIX_DATA, oX, oY} <= {pendData, pendX, pendY};
            if (pixStrobe) {pendData, pendX, pendY} <= {hiByte, s1Data, x, y};
            if (frameStart) {x, y, phase} <= '0;
            else if (!inActive) phase <= 1'b0;
            else if (hrefFall) begin
                x     <= '0;
                y     <= y < VMAX ? y + 9'd1 : y;
                phase <= 1'b0;
            end
            else if (pixStrobe) begin
                x     <= x < HMAX ? x + 10'd1 : x;
                phase <= 1'b0;
            end
            else if (s1Href) begin
                hiByte <= s1Data;
                phase  <= 1'b1;
            end
        end

`ifdef CMOS_CAPTURE_STATS_EN
    logic lineErr, xOver, yOver;
    // x and y saturate, so overflow past the active size is tracked separately
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) {lineErr, xOver, yOver, oFRAME_CNT, oSIZE_ERR} <= '0;
        else begin
            if (frameStart) {lineErr, xOver, yOver} <= '0;
            else if (inActive && hrefFall) begin
                lineErr <= lineErr | (x != HMAX) | xOver;
                xOver   <= 1'b0;
                yOver   <= yOver | (y == VMAX);
            end
            else if (pixStrobe && x == HMAX) xOver <= 1'b1;
            if (frameDone) begin
                oFRAME_CNT <= oFRAME_CNT + 16'd1;
                oSIZE_ERR  <= oSIZE_ERR | lineErr | yOver | (y != VMAX);
            end
        end
`endif
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: directed checks of skip, pairing, saturation, abort and reset behaviour
module tb_cmos_capture;
    logic        iCLK = 0, iRST_N = 0, iCONFIG_DONE = 0, iVSYNC = 1, iHREF = 0;
    logic [7:0]  iDATA = 0;
    logic [15:0] oPIX_DATA, zPIX_DATA;
    logic        oPIX_VALID, oFRAME_START, oFRAME_DONE, oCAPTURING;
    logic        zPIX_VALID, zFRAME_START, zFRAME_DONE, zCAPTURING;
    logic [9:0]  oX, zX;
    logic [8:0]  oY, zY;
`ifdef CMOS_CAPTURE_STATS_EN
    logic [15:0] oFRAME_CNT, zFRAME_CNT;
    logic        oSIZE_ERR, zSIZE_ERR;
`endif
    int checks = 0, failures = 0;
    int nPix = 0, nStart = 0, nDone = 0;
    logic [9:0]  xLog [256];
    logic [8:0]  yLog [256];
    logic [15:0] dLog [256];

    always #5 iCLK = ~iCLK;

    cmos_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .SKIP_FRAMES(2)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCONFIG_DONE(iCONFIG_DONE), .iVSYNC(iVSYNC),
        .iHREF(iHREF), .iDATA(iDATA), .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID),
        .oX(oX), .oY(oY), .oFRAME_START(oFRAME_START), .oFRAME_DONE(oFRAME_DONE),
        .oCAPTURING(oCAPTURING)
`ifdef CMOS_CAPTURE_STATS_EN
       ,.oFRAME_CNT(oFRAME_CNT), .oSIZE_ERR(oSIZE_ERR)
`endif
    );

    cmos_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .SKIP_FRAMES(0)) dutNoSkip (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCONFIG_DONE(iCONFIG_DONE), .iVSYNC(iVSYNC),
        .iHREF(iHREF), .iDATA(iDATA), .oPIX_DATA(zPIX_DATA), .oPIX_VALID(zPIX_VALID),
        .oX(zX), .oY(zY), .oFRAME_START(zFRAME_START), .oFRAME_DONE(zFRAME_DONE),
        .oCAPTURING(zCAPTURING)
`ifdef CMOS_CAPTURE_STATS_EN
       ,.oFRAME_CNT(zFRAME_CNT), .oSIZE_ERR(zSIZE_ERR)
`endif
    );

    always @(negedge iCLK) begin
        if (oPIX_VALID) begin
            xLog[nPix[7:0]] <= oX;
            yLog[nPix[7:0]] <= oY;
            dLog[nPix[7:0]] <= oPIX_DATA;
            nPix <= nPix + 1;
        end
        if (oFRAME_START) nStart <= nStart + 1;
        if (oFRAME_DONE) nDone <= nDone + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic sendLine(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            iHREF = 1;
            iDATA = base + 8'(i);
            tick(1);
        end
        iHREF = 0;
        tick(3);
    endtask

    task automatic frame(input int lines, input int bytes);
        iVSYNC = 1;
        tick(3);
        iVSYNC = 0;
        tick(3);
        for (int l = 0; l < lines; l++) sendLine(bytes, 8'h10);
    endtask

    task automatic test_reset;
        iRST_N = 0;
        tick(2);
        checks++; if (oPIX_DATA !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0000", oPIX_DATA); end
        checks++; if ({oPIX_VALID, oFRAME_START, oFRAME_DONE, oCAPTURING} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {oPIX_VALID, oFRAME_START, oFRAME_DONE, oCAPTURING}); end
        checks++; if ({oX, oY} !== 19'h0) begin failures++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", oX, oY); end
        iRST_N = 1;
        tick(3);
        checks++; if (oCAPTURING !== 1'b0) begin failures++; $display("FAIL nocfg_capturing got=%b exp=0", oCAPTURING); end
    endtask

    task automatic test_skip;
        int p, s, d;
        p = nPix; s = nStart; d = nDone;
        iCONFIG_DONE = 1;
        tick(2);
        checks++; if (zCAPTURING !== 1'b1) begin failures++; $display("FAIL skip0_capturing got=%b exp=1", zCAPTURING); end
        checks++; if (oCAPTURING !== 1'b0) begin failures++; $display("FAIL skip_state got=%b exp=0", oCAPTURING); end
        frame(2, 4);
        checks++; if (oCAPTURING !== 1'b0) begin failures++; $display("FAIL skip_after_f1 got=%b exp=0", oCAPTURING); end
        frame(2, 4);
        checks++; if (oCAPTURING !== 1'b1) begin failures++; $display("FAIL skip_after_f2 got=%b exp=1", oCAPTURING); end
        checks++; if (nPix !== p || nStart !== s) begin failures++; $display("FAIL skip_nopix got=%0d/%0d exp=%0d/%0d", nPix, nStart, p, s); end
        iVSYNC = 1;
        tick(3);
        iVSYNC = 0;
        tick(1);
        checks++; if (oFRAME_START !== 1'b0) begin failures++; $display("FAIL fs_early got=%b exp=0", oFRAME_START); end
        tick(1);
        checks++; if (oFRAME_START !== 1'b1) begin failures++; $display("FAIL fs_pulse got=%b exp=1", oFRAME_START); end
        tick(1);
        checks++; if (oFRAME_START !== 1'b0) begin failures++; $display("FAIL fs_width got=%b exp=0", oFRAME_START); end
        sendLine(4, 8'h10);
        sendLine(4, 8'h10);
        iVSYNC = 1;
        tick(3);
        checks++; if (nPix !== p + 4 || nStart !== s + 1 || nDone !== d + 1) begin failures++; $display("FAIL f3_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", nPix - p, nStart - s, nDone - d, 4, 1, 1); end
    endtask

    task automatic test_pixel;
        iVSYNC = 0;
        tick(3);
        iHREF = 1; iDATA = 8'hF8;
        tick(1);
        iDATA = 8'h1F;
        tick(1);
        iHREF = 0; iDATA = 8'h00;
        checks++; if (oPIX_VALID !== 1'b0) begin failures++; $display("FAIL pix_lat1 got=%b exp=0", oPIX_VALID); end
        tick(1);
        checks++; if (oPIX_VALID !== 1'b0) begin failures++; $display("FAIL pix_lat2 got=%b exp=0", oPIX_VALID); end
        tick(1);
        checks++; if (oPIX_VALID !== 1'b1) begin failures++; $display("FAIL pix_valid got=%b exp=1", oPIX_VALID); end
        checks++; if (oPIX_DATA !== 16'hF81F) begin failures++; $display("FAIL pix_data got=%h exp=f81f", oPIX_DATA); end
        checks++; if (oX !== 10'd0 || oY !== 9'd0) begin failures++; $display("FAIL pix_xy got=%0d,%0d exp=0,0", oX, oY); end
        tick(1);
        checks++; if (oPIX_VALID !== 1'b0 || oPIX_DATA !== 16'hF81F) begin failures++; $display("FAIL pix_hold got=%b/%h exp=0/f81f", oPIX_VALID, oPIX_DATA); end
        tick(2);
    endtask

    task automatic test_odd_line;
        int p;
        p = nPix;
        sendLine(7, 8'h20);
        sendLine(4, 8'h40);
        checks++; if (nPix !== p + 5) begin failures++; $display("FAIL odd_count got=%0d exp=5", nPix - p); end
        checks++; if (xLog[p+2] !== 10'd2 || yLog[p+2] !== 9'd1 || dLog[p+2] !== 16'h2425) begin failures++; $display("FAIL odd_third got=%0d,%0d,%h exp=2,1,2425", xLog[p+2], yLog[p+2], dLog[p+2]); end
        checks++; if (xLog[p+3] !== 10'd0 || yLog[p+3] !== 9'd2 || dLog[p+3] !== 16'h4041) begin failures++; $display("FAIL odd_next got=%0d,%0d,%h exp=0,2,4041", xLog[p+3], yLog[p+3], dLog[p+3]); end
    endtask

    task automatic test_saturate;
        int p;
        p = nPix;
        sendLine(12, 8'h60);
        checks++; if (nPix !== p + 4) begin failures++; $display("FAIL hsat_count got=%0d exp=4", nPix - p); end
        checks++; if (xLog[p+3] !== 10'd3 || dLog[p+3] !== 16'h6667) begin failures++; $display("FAIL hsat_last got=%0d,%h exp=3,6667", xLog[p+3], dLog[p+3]); end
        sendLine(4, 8'h70);
        checks++; if (nPix !== p + 4) begin failures++; $display("FAIL vsat_count got=%0d exp=4", nPix - p); end
    endtask

    task automatic test_abort;
        int p, d, s;
        d = nDone;
        iVSYNC = 1;
        tick(3);
        iVSYNC = 0;
        tick(3);
        p = nPix;
        for (int i = 0; i < 6; i++) begin
            iHREF = 1;
            iDATA = 8'hA0 + 8'(i);
            if (i == 2) iVSYNC = 1;
            tick(1);
        end
        iHREF = 0;
        tick(4);
        checks++; if (nPix !== p + 1 || dLog[p] !== 16'hA0A1) begin failures++; $display("FAIL abort_pix got=%0d,%h exp=1,a0a1", nPix - p, dLog[p]); end
        checks++; if (nDone !== d + 2) begin failures++; $display("FAIL abort_done got=%0d exp=2", nDone - d); end
        checks++; if (oCAPTURING !== 1'b1) begin failures++; $display("FAIL abort_state got=%b exp=1", oCAPTURING); end
        s = nStart;
        iVSYNC = 0;
        tick(3);
        checks++; if (nStart !== s + 1) begin failures++; $display("FAIL abort_resume got=%0d exp=1", nStart - s); end
    endtask

    task automatic test_reset_mid;
        int p, s;
        for (int i = 0; i < 3; i++) begin
            iHREF = 1;
            iDATA = 8'h55;
            tick(1);
        end
        iRST_N = 0;
        #1;
        checks++; if ({oPIX_DATA, oX, oY} !== 35'h0) begin failures++; $display("FAIL mrst_data got=%h,%0d,%0d exp=0,0,0", oPIX_DATA, oX, oY); end
        checks++; if ({oPIX_VALID, oFRAME_START, oFRAME_DONE, oCAPTURING} !== 4'b0) begin failures++; $display("FAIL mrst_flags got=%b exp=0000", {oPIX_VALID, oFRAME_START, oFRAME_DONE, oCAPTURING}); end
        tick(1);
        iRST_N = 1;
        iHREF = 0;
        p = nPix; s = nStart;
        tick(2);
        frame(4, 8);
        frame(4, 8);
        checks++; if (nPix !== p || nStart !== s) begin failures++; $display("FAIL mrst_skip got=%0d/%0d exp=0/0", nPix - p, nStart - s); end
        frame(4, 8);
        iVSYNC = 1;
        tick(3);
        checks++; if (nPix !== p + 16 || nStart !== s + 1) begin failures++; $display("FAIL mrst_frame got=%0d/%0d exp=16/1", nPix - p, nStart - s); end
`ifdef CMOS_CAPTURE_STATS_EN
        checks++; if (oFRAME_CNT !== 16'd1 || oSIZE_ERR !== 1'b0) begin failures++; $display("FAIL stats_full got=%0d/%b exp=1/0", oFRAME_CNT, oSIZE_ERR); end
        iVSYNC = 0;
        tick(3);
        sendLine(8, 8'h30);
        iVSYNC = 1;
        tick(3);
        checks++; if (oFRAME_CNT !== 16'd2 || oSIZE_ERR !== 1'b1) begin failures++; $display("FAIL stats_short got=%0d/%b exp=2/1", oFRAME_CNT, oSIZE_ERR); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_skip;
        test_pixel;
        test_odd_line;
        test_saturate;
        test_abort;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
